// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package seq_det_pkg;

  localparam int OVL_ON    = 1;
  localparam int OVL_OFF   = 0;
  localparam int MAX_WIDTH = 16;

  // Alternating 1010... pattern, MSB first, right-aligned in MAX_WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] reset_pattern(input int width);
    logic [MAX_WIDTH-1:0] p;
    p = {MAX_WIDTH{1'b0}};
    for (int k = 0; k < MAX_WIDTH; k++) begin
      if ((k < width) && (((width - 1 - k) % 2) == 0)) begin
        p[k] = 1'b1;
      end else begin
        p[k] = 1'b0;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag and synchronous clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  // Next-state: a clear coinciding with an event counts that event.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: shift history plus fill counter compared against a
// loadable pattern, with a zero-latency Mealy match flag and a match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             R_n,
  input  logic             in,
  input  logic             en,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             pat_load,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             ovf
);

  localparam int                FILL_W   = $clog2(WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  RST_PAT  = WIDTH'(reset_pattern(WIDTH));

  logic [WIDTH-2:0]  hist_d, hist_q;
  logic [FILL_W-1:0] fill_d, fill_q;
  logic [WIDTH-1:0]  pat_d, pat_q;
  logic [WIDTH-1:0]  window_s;
  logic              match_s;

  // Match needs a full window of valid bits; a load cycle never matches.
  always_comb begin
    window_s = {hist_q, in};
    match_s  = en & ~pat_load & (fill_q == FILL_MAX) & (window_s == pat_q);
  end

  // History/fill/pattern next state; load wins over enable.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = {(WIDTH-1){1'b0}};
      fill_d = {FILL_W{1'b0}};
    end else if (en) begin
      if (match_s && (OVERLAP == OVL_OFF)) begin
        hist_d = {(WIDTH-1){1'b0}};
        fill_d = {FILL_W{1'b0}};
      end else begin
        hist_d = window_s[WIDTH-2:0];
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : (fill_q + FILL_W'(1));
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      hist_q <= {(WIDTH-1){1'b0}};
      fill_q <= {FILL_W{1'b0}};
      pat_q  <= RST_PAT;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(R_n),
    .clr  (cnt_clr),
    .inc  (match_s),
    .cnt  (match_cnt),
    .ovf  (ovf)
  );

  assign out = match_s;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: four detector configurations driven in parallel, checked
// by directed scenarios and a randomized run against a bit-count reference model.
module tb_seq_detector_param;

  logic        clk = 1'b0;
  logic        R_n;
  logic        in_s, en_s, pl_s, clr_s;
  logic [15:0] pin_s;
  logic [3:0]  out_s, ovf_s;
  logic [7:0]  cnt0, cnt1, cnt3;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  int pw[4]  = '{3, 3, 3, 4};
  int pov[4] = '{1, 0, 1, 1};
  int pcw[4] = '{8, 8, 2, 8};

  // Reference model: pattern, bit history, valid-bit count since restart, counter.
  int mpat[4], mhist[4], mnv[4], mcnt[4], movf[4];

  always #5 clk = ~clk;

  seq_detector_param #(.WIDTH(3), .OVERLAP(1), .CNT_W(8)) d0 (
    .clk(clk), .R_n(R_n), .in(in_s), .en(en_s), .pat_in(pin_s[2:0]), .pat_load(pl_s),
    .cnt_clr(clr_s), .out(out_s[0]), .match_cnt(cnt0), .ovf(ovf_s[0]));
  seq_detector_param #(.WIDTH(3), .OVERLAP(0), .CNT_W(8)) d1 (
    .clk(clk), .R_n(R_n), .in(in_s), .en(en_s), .pat_in(pin_s[2:0]), .pat_load(pl_s),
    .cnt_clr(clr_s), .out(out_s[1]), .match_cnt(cnt1), .ovf(ovf_s[1]));
  seq_detector_param #(.WIDTH(3), .OVERLAP(1), .CNT_W(2)) d2 (
    .clk(clk), .R_n(R_n), .in(in_s), .en(en_s), .pat_in(pin_s[2:0]), .pat_load(pl_s),
    .cnt_clr(clr_s), .out(out_s[2]), .match_cnt(cnt2), .ovf(ovf_s[2]));
  seq_detector_param #(.WIDTH(4), .OVERLAP(1), .CNT_W(8)) d3 (
    .clk(clk), .R_n(R_n), .in(in_s), .en(en_s), .pat_in(pin_s[3:0]), .pat_load(pl_s),
    .cnt_clr(clr_s), .out(out_s[3]), .match_cnt(cnt3), .ovf(ovf_s[3]));

  function automatic int rst_pat(int w);
    int v = 0;
    for (int j = 0; j < w; j += 2) v += (1 << (w - 1 - j));
    return v;
  endfunction

  function automatic bit exp_out(int i);
    int win;
    win = ((mhist[i] << 1) | int'(in_s)) & ((1 << pw[i]) - 1);
    return (en_s == 1'b1) && (pl_s == 1'b0) && (mnv[i] >= pw[i] - 1) && (win == mpat[i]);
  endfunction

  function automatic int dut_cnt(int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mpat[i] = rst_pat(pw[i]); mhist[i] = 0; mnv[i] = 0; mcnt[i] = 0; movf[i] = 0;
    end
  endtask

  // Reset pulse placed just after a rising edge, well clear of the next one.
  task automatic pulse_reset();
    R_n = 1'b0;
    #2;
    R_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input logic b, input logic e, input logic pl, input logic clr,
                       input logic [15:0] pin);
    in_s = b; en_s = e; pl_s = pl; clr_s = clr; pin_s = pin;
    @(negedge clk);
  endtask

  task automatic advance();
    bit m[4];
    for (int i = 0; i < 4; i++) m[i] = exp_out(i);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pl_s) begin
        mpat[i] = int'(pin_s) & ((1 << pw[i]) - 1); mhist[i] = 0; mnv[i] = 0;
      end else if (en_s) begin
        if (m[i] && pov[i] == 0) begin
          mhist[i] = 0; mnv[i] = 0;
        end else begin
          mhist[i] = ((mhist[i] << 1) | int'(in_s)) & 16'hFFFF;
          if (mnv[i] < 100) mnv[i]++;
        end
      end
      if (clr_s) begin
        mcnt[i] = m[i] ? 1 : 0; movf[i] = 0;
      end else if (m[i]) begin
        if (mcnt[i] == (1 << pcw[i]) - 1) movf[i] = 1;
        else mcnt[i]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    R_n = 1'b0;
    in_s = 1'b1; en_s = 1'b1; pl_s = 1'b0; clr_s = 1'b0; pin_s = 16'h0005;
    model_reset();
    #3;
    checks++;
    if (out_s !== 4'b0000) begin errors++; $display("FAIL reset_out got %b exp 0000", out_s); end
    checks++;
    if ({cnt0, cnt1, cnt3} !== 24'h0 || cnt2 !== 2'b00 || ovf_s !== 4'b0000) begin
      errors++; $display("FAIL reset_cnt got %h %h %h %h ovf %b exp zeros", cnt0, cnt1, cnt2, cnt3, ovf_s);
    end
    @(posedge clk); #1;
    R_n = 1'b1;
  endtask

  task automatic test_basic_101();
    logic [4:0] bits;
    logic [4:0] o0, o1;
    bits = 5'b10101;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      drive(bits[4-k], 1'b1, 1'b0, 1'b0, 16'h0005);
      o0[k] = out_s[0]; o1[k] = out_s[1];
      advance();
    end
    checks++;
    if (o0 !== 5'b10100) begin errors++; $display("FAIL ovl_outs got %b exp 10100", o0); end
    checks++;
    if (o1 !== 5'b00100) begin errors++; $display("FAIL novl_outs got %b exp 00100", o1); end
    checks++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd1) begin
      errors++; $display("FAIL basic_cnt got %0d/%0d exp 2/1", cnt0, cnt1);
    end
  endtask

  task automatic test_en_gap();
    logic [6:0] o3;
    pulse_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h000C); advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h000C); o3[0] = out_s[3]; advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h000C); o3[1] = out_s[3]; advance();
    for (int k = 2; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h000C); o3[k] = out_s[3]; advance();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h000C); o3[5] = out_s[3]; advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h000C); o3[6] = out_s[3]; advance();
    checks++;
    if (o3 !== 7'b1000000) begin errors++; $display("FAIL gap_outs got %b exp 1000000", o3); end
    checks++;
    if (cnt3 !== 8'd1) begin errors++; $display("FAIL gap_cnt got %0d exp 1", cnt3); end
  endtask

  task automatic test_load_restart();
    pulse_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005); advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005);
    checks++;
    if (out_s[0] !== 1'b0) begin errors++; $display("FAIL load_cycle_out got %b exp 0", out_s[0]); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005);
    checks++;
    if (out_s[0] !== 1'b0) begin errors++; $display("FAIL after_load_out got %b exp 0", out_s[0]); end
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005);
    checks++;
    if (out_s[0] !== 1'b1) begin errors++; $display("FAIL fresh_match_out got %b exp 1", out_s[0]); end
    advance();
  endtask

  task automatic test_saturate();
    pulse_reset();
    for (int k = 0; k < 11; k++) begin
      drive(((k % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    end
    checks++;
    if (cnt2 !== 2'd3 || ovf_s[2] !== 1'b1) begin
      errors++; $display("FAIL sat_cnt got %0d ovf %b exp 3 ovf 1", cnt2, ovf_s[2]);
    end
    checks++;
    if (cnt0 !== 8'd5 || ovf_s[0] !== 1'b0) begin
      errors++; $display("FAIL wide_cnt got %0d ovf %b exp 5 ovf 0", cnt0, ovf_s[0]);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0005);
    checks++;
    if (out_s[2] !== 1'b1) begin errors++; $display("FAIL clr_match_out got %b exp 1", out_s[2]); end
    advance();
    checks++;
    if (cnt2 !== 2'd1 || ovf_s[2] !== 1'b0) begin
      errors++; $display("FAIL clr_match_cnt got %0d ovf %b exp 1 ovf 0", cnt2, ovf_s[2]);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    in_s = 1'b1; en_s = 1'b1;
    R_n = 1'b0;
    #1;
    checks++;
    if (out_s !== 4'b0000 || cnt0 !== 8'd0) begin
      errors++; $display("FAIL in_reset got out %b cnt %0d exp 0000 0", out_s, cnt0);
    end
    #1;
    R_n = 1'b1;
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005);
    checks++;
    if (out_s[0] !== 1'b0) begin errors++; $display("FAIL post_reset_out got %b exp 0", out_s[0]); end
    advance();
    checks++;
    if (cnt0 !== 8'd0) begin errors++; $display("FAIL post_reset_cnt got %0d exp 0", cnt0); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005); advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005);
    checks++;
    if (out_s[0] !== 1'b1) begin errors++; $display("FAIL reset_pat_out got %b exp 1", out_s[0]); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(1)), ($urandom_range(3) != 0), ($urandom_range(29) == 0),
            ($urandom_range(19) == 0), 16'($urandom_range(15)));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_s[i] !== exp_out(i)) begin
          errors++; $display("FAIL rand_out[%0d] cyc %0d got %b exp %b", i, n, out_s[i], exp_out(i));
        end
      end
      advance();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_cnt(i) != mcnt[i] || int'(ovf_s[i]) != movf[i]) begin
          errors++;
          $display("FAIL rand_cnt[%0d] cyc %0d got %0d ovf %b exp %0d ovf %0d",
                   i, n, dut_cnt(i), ovf_s[i], mcnt[i], movf[i]);
        end
      end
      if ($urandom_range(99) == 0) pulse_reset();
    end
  endtask

  initial begin
    test_reset();
    test_basic_101();
    test_en_gap();
    test_load_restart();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
